serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit adder: the addition counterpart to the ALU's ripple subtractor.
//  Latches two operands on a start request and adds one bit per clock, LSB first, through one full-adder cell.
//  Reports sum, carry and signed overflow, with a done pulse.
//  Serves as the low-area ADD path of the ALU; the datapath sequencer drives start/done.
// PARAMETERS
//  N   16             operand/sum width in bits (N >= 2)
//  CW  $clog2(N)      bit-counter width (derived; do not override)
// PORTS
//  clk        in   1   single system clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   request: sample a/b and begin an addition
//  a          in   N   operand A (unsigned / two's complement)
//  b          in   N   operand B
//  busy       out  1   high while an addition is in progress (RUN)
//  done       out  1   one-cycle pulse: result outputs just updated
//  sum        out  N   result A+B mod 2^N, held until next completion
//  carry_out  out  1   unsigned carry out of bit N-1
//  overflow   out  1   signed overflow = carry into bit N-1 XOR carry_out
// BEHAVIOUR
//  Reset: rst high at a rising edge returns state to IDLE and clears all registers.
//   busy=0, done=0, sum=0, carry_out=0, overflow=0. This holds in any state, including mid-RUN.
//   A partial result is discarded and never presented.
//  States: IDLE, RUN, DONE (encoding from shared package).
//   IDLE: start=1 loads a_sh<=a, b_sh<=b, carry<=0, cnt<=0, acc<=0, and moves to RUN. start=0 stays in IDLE.
//   RUN, each edge:
//    {c_nxt,s} = a_sh[0]+b_sh[0]+carry.
//    acc <= {s, acc[N-1:1]}; a_sh, b_sh shift right by 1; carry <= c_nxt; cnt <= cnt+1.
//    On the edge where cnt==N-1, also:
//     sum <= {s, acc[N-1:1]}; carry_out <= c_nxt; overflow <= carry ^ c_nxt.
//     done <= 1; move to DONE.
//   DONE: lasts exactly one cycle; done deasserts on the next edge.
//    start=1 in DONE loads new operands and goes straight to RUN (back-to-back).
//    Otherwise it goes to IDLE.
//  Latency: start sampled at edge k; done is high during the cycle after edge k+N.
//   Throughput is one addition per N+1 cycles with back-to-back starts.
//  busy=1 exactly in RUN. start while busy is ignored; operands already latched are unaffected.
//  a/b are sampled only at the accepting edge. Later changes have no effect.
//  sum/carry_out/overflow change only on the completing edge (and on reset). They are stable at all other times.
//  Width rules: sum is mod 2^N. The carry flop is 1 bit. cnt wraps to 0 on each new load and never exceeds N-1.
// STRUCTURE
//  Shared package/header: state encodings (IDLE/RUN/DONE) and the ALU default width constant (16).
//  One sub-module: full_adder_bit (x, y, c_in -> s, c_out), pure combinational, instantiated once.
//  Everything else (shifters, counter, FSM, result regs) lives in serial_adder.
// TESTING
//  1. rst for 2 cycles -> all outputs 0, busy=0. Then a=5432, b=1234, start one cycle.
//     -> busy for 16 cycles, done pulse at edge k+16, sum=6666 (0x1A0A), carry_out=0, overflow=0.
//  2. a=0xFFFF, b=0x0001 -> sum=0x0000, carry_out=1, overflow=0.
//     Then a=0x7FFF, b=0x0001 -> sum=0x8000, carry_out=0, overflow=1.
//  3. a=0x8000, b=0x8000 -> sum=0x0000, carry_out=1, overflow=1.
//     Prior sum stays stable throughout RUN until the done edge.
//  4. Start a=100, b=23. At RUN cycle 5, change a/b and pulse start again.
//     -> ignored; done at edge k+16 with sum=123, exactly one done pulse.
//  5. Start a=0x1234, b=0x1111. Assert rst at RUN cycle 7.
//     -> next cycle IDLE, busy=0, sum=0, no done.
//     A fresh start then yields a correct sum in 16 cycles.
//  6. Back-to-back: start held high.
//     -> first done at k+16, second operands accepted in the DONE cycle, second done at k+33.
//     Each result is correct against the reference model a+b.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial ADD path: FSM encodings and the ALU default width.
package serial_adder_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between the datapath sequencer (master) and the serial adder (slave).
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int N = ALU_WIDTH
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         overflow;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out, overflow
  );

endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// Single full-adder cell; the serial adder pushes one operand bit pair through it per clock.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: latches a/b on start, adds one bit per clock LSB first,
// then presents sum, unsigned carry and signed overflow with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = ALU_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(N);

  state_e        state_r;
  logic [N-1:0]  a_sh_r;
  logic [N-1:0]  b_sh_r;
  // Holds the N-1 lower sum bits already produced; the last bit comes straight from the cell.
  logic [N-2:0]  acc_r;
  logic          carry_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic          done_r;
  logic [N-1:0]  sum_r;
  logic          carry_out_r;
  logic          overflow_r;

  logic          bit_sum_s;
  logic          bit_carry_s;
  logic [N-1:0]  acc_nxt_s;

  full_adder_bit u_fa (
    .x     (a_sh_r[0]),
    .y     (b_sh_r[0]),
    .c_in  (carry_r),
    .s     (bit_sum_s),
    .c_out (bit_carry_s)
  );

  assign acc_nxt_s = {bit_sum_s, acc_r};

  // Control FSM, operand shifters, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      a_sh_r      <= {N{1'b0}};
      b_sh_r      <= {N{1'b0}};
      acc_r       <= {(N-1){1'b0}};
      carry_r     <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sum_r       <= {N{1'b0}};
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        // DONE behaves like IDLE for accepting work, which gives back-to-back throughput.
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            acc_r   <= {(N-1){1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[N-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[N-1:1]};
          acc_r   <= acc_nxt_s[N-1:1];
          carry_r <= bit_carry_s;
          if (cnt_r == CW'(N-1)) begin
            // carry_r here is the carry into the MSB, so XOR with its carry-out gives signed overflow.
            sum_r       <= acc_nxt_s;
            carry_out_r <= bit_carry_s;
            overflow_r  <= carry_r ^ bit_carry_s;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            state_r     <= ST_DONE;
          end else begin
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            cnt_r   <= cnt_r + CW'(1);
            state_r <= ST_RUN;
          end
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: scoreboard of a+b results checked on every done pulse,
// plus latency, busy, stability, ignored-start, mid-run reset and back-to-back checks.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int N = ALU_WIDTH;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   done_cnt;
  logic [N+1:0] sb_q[$];

  serial_adder_if #(.N(N)) bus ();

  serial_adder #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry_out, overflow, sum} from ordinary wide addition and sign comparison.
  function automatic logic [N+1:0] model(input logic [N-1:0] av, input logic [N-1:0] bv);
    logic [N:0] full;
    logic       ovf;
    full = {1'b0, av} + {1'b0, bv};
    ovf  = (av[N-1] == bv[N-1]) && (full[N-1] != av[N-1]);
    return {full[N], ovf, full[N-1:0]};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      logic [N+1:0] e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("sb_sum",       32'(bus.sum),       32'(e[N-1:0]));
        check("sb_carry_out", 32'(bus.carry_out), 32'(e[N+1]));
        check("sb_overflow",  32'(bus.overflow),  32'(e[N]));
      end
    end
  end

  task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    sb_q.push_back(model(av, bv));
    tick();
    bus.start = 1'b0;
  endtask

  // Called just after the accepting edge; waits (bounded) for done, checking busy and result stability.
  task automatic wait_done(input string tag, input logic [N-1:0] prior, input bit hold,
                           input int glitch_at, input int exp_lat);
    int lat;
    bit stable;
    lat    = 0;
    stable = 1'b1;
    check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
    while (bus.done !== 1'b1 && lat < 40) begin
      bus.start = hold || (lat == glitch_at);
      if (lat == glitch_at) begin
        bus.a = 16'hDEAD;
        bus.b = 16'hBEEF;
      end
      if (bus.sum !== prior) stable = 1'b0;
      tick();
      lat++;
    end
    if (!hold) bus.start = 1'b0;
    check({tag, "_latency"},   32'(lat),      32'(exp_lat));
    check({tag, "_sum_stable"}, 32'(stable),  32'd1);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int d0;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    n_cmp     = 0;
    n_bad     = 0;
    done_cnt  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    tick();
    tick();
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_carry_out", 32'(bus.carry_out), 32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    rst = 1'b0;
    tick();

    // 1: basic add, 5432 + 1234 = 6666
    start_op(16'd5432, 16'd1234);
    wait_done("t1", 16'h0000, 1'b0, -1, 16);
    check("t1_sum_direct", 32'(bus.sum), 32'h1A0A);
    tick();
    check("t1_done_one_cycle", 32'(bus.done), 32'd0);

    // 2: unsigned wrap, then signed overflow
    start_op(16'hFFFF, 16'h0001);
    wait_done("t2a", 16'h1A0A, 1'b0, -1, 16);
    tick();
    start_op(16'h7FFF, 16'h0001);
    wait_done("t2b", 16'h0000, 1'b0, -1, 16);
    check("t2b_overflow_direct", 32'(bus.overflow), 32'd1);
    tick();

    // 3: both flags set; sum stays 0x8000 throughout RUN
    start_op(16'h8000, 16'h8000);
    wait_done("t3", 16'h8000, 1'b0, -1, 16);
    tick();

    // 4: start while busy (RUN cycle 5) is ignored
    d0 = done_cnt;
    start_op(16'd100, 16'd23);
    wait_done("t4", 16'h0000, 1'b0, 4, 16);
    check("t4_sum_direct", 32'(bus.sum), 32'd123);
    repeat (20) tick();
    check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

    // 5: reset in the middle of a run discards the partial result
    d0 = done_cnt;
    start_op(16'h1234, 16'h1111);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb_q.pop_back());
    check("t5_busy", 32'(bus.busy),      32'd0);
    check("t5_sum",  32'(bus.sum),       32'd0);
    check("t5_done", 32'(bus.done),      32'd0);
    check("t5_co",   32'(bus.carry_out), 32'd0);
    repeat (20) tick();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    start_op(16'h1234, 16'h1111);
    wait_done("t5b", 16'h0000, 1'b0, -1, 16);
    check("t5b_sum_direct", 32'(bus.sum), 32'h2345);
    tick();

    // 6: back-to-back with start held high: second done 33 cycles after the first accept
    bus.a     = 16'hABCD;
    bus.b     = 16'h6543;
    bus.start = 1'b1;
    sb_q.push_back(model(16'hABCD, 16'h6543));
    tick();
    bus.a = 16'h4000;
    bus.b = 16'h4000;
    sb_q.push_back(model(16'h4000, 16'h4000));
    wait_done("t6a", 16'h2345, 1'b1, -1, 16);
    tick();
    bus.start = 1'b0;
    wait_done("t6b", 16'h1110, 1'b0, -1, 16);
    tick();

    // A few random operand pairs through the scoreboard
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      start_op(ra, rb);
      wait_done("rnd", bus.sum, 1'b0, -1, 16);
      tick();
    end

    repeat (3) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
